// File: rtl/slot_game_ctrl.sv
// slot_game_ctrl - game sequencer for the slot-machine datapath.
//
// Takes debounced coin and spin pulses. On an accepted spin it debits the bet
// and runs all four reels, then stops them in staggered order. It evaluates
// the frozen digits and credits any payout. This block is the only writer of
// the balance register.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   coin_1/10/50/100              single-cycle credit pulses
//   spin                          single-cycle spin request
//   bet_sel[1:0]                  bet size 1/5/10/50, sampled at acceptance
//   reel0..reel3[3:0]             live reel digits from the reel generator
//   reel_run[3:0]                 per-reel run enables
//   balance, win_amt[BAL_W-1:0]   current credit, payout of the last spin
//   busy, insufficient, state[2:0] status outputs
//
// Build option: define SLOT_JACKPOT_EN to make four 7s pay 500x the bet.
module slot_game_ctrl #(
    parameter int BAL_W    = 27,
    parameter int SPIN_CYC = 50,
    parameter int STAGGER  = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_1,
    input  logic             coin_10,
    input  logic             coin_50,
    input  logic             coin_100,
    input  logic             spin,
    input  logic [1:0]       bet_sel,
    input  logic [3:0]       reel0,
    input  logic [3:0]       reel1,
    input  logic [3:0]       reel2,
    input  logic [3:0]       reel3,
    output logic [3:0]       reel_run,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] win_amt,
    output logic             busy,
    output logic             insufficient,
    output logic [2:0]       state
);
    localparam int AW      = BAL_W + 8;
    localparam int CNT_MAX = (SPIN_CYC > STAGGER) ? SPIN_CYC : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SPIN = 3'd1;
    localparam logic [2:0] S_STOP = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

    localparam logic [AW-1:0] BAL_MAX = AW'({BAL_W{1'b1}});

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       reel_run_q, reel_run_d;
    logic [5:0]       bet_q, bet_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [BAL_W-1:0] win_amt_q, win_amt_d;
    logic             insufficient_q, insufficient_d;

    logic [5:0]    bet_req;
    logic [AW-1:0] debit, coin_sum, payout, pay_calc, sum, b;

    always_comb begin
        case (bet_sel)
            2'b00:   bet_req = 6'd1;
            2'b01:   bet_req = 6'd5;
            2'b10:   bet_req = 6'd10;
            default: bet_req = 6'd50;
        endcase
    end

    // Payout from the latched digits and bet; multiplies are shift-adds.
    always_comb begin
        b        = AW'(bet_q);
        pay_calc = '0;
`ifdef SLOT_JACKPOT_EN
        if (digit_q[0] == 4'd7 && digit_q[1] == 4'd7 &&
            digit_q[2] == 4'd7 && digit_q[3] == 4'd7)
            pay_calc = (b << 8) + (b << 7) + (b << 6) + (b << 5) + (b << 4) + (b << 2);
        else
`endif
        if (digit_q[0] == digit_q[1] && digit_q[1] == digit_q[2] && digit_q[2] == digit_q[3])
            pay_calc = (b << 6) + (b << 5) + (b << 2);
        else if (digit_q[0] == digit_q[1] && digit_q[1] == digit_q[2])
            pay_calc = (b << 3) + (b << 1);
        else if (digit_q[0] == digit_q[1])
            pay_calc = b << 1;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        reel_run_d     = reel_run_q;
        bet_d          = bet_q;
        digit_d        = digit_q;
        win_amt_d      = win_amt_q;
        insufficient_d = 1'b0;
        debit          = '0;
        payout         = '0;

        case (state_q)
            S_IDLE: begin
                if (spin) begin
                    // Affordability uses the pre-update balance; same-cycle coins don't count.
                    if (AW'(balance_q) >= AW'(bet_req)) begin
                        bet_d      = bet_req;
                        debit      = AW'(bet_req);
                        reel_run_d = 4'b1111;
                        cnt_d      = '0;
                        state_d    = S_SPIN;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end
            end
            S_SPIN: begin
                if (cnt_q == CNT_W'(SPIN_CYC - 1)) begin
                    cnt_d      = '0;
                    reel_run_d = 4'b1110;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Shifting left clears the next reel's enable, lowest reel first.
                if (reel_run_q == 4'b0000) begin
                    state_d = S_EVAL;
                end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    cnt_d      = '0;
                    reel_run_d = reel_run_q << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                digit_d = {reel3, reel2, reel1, reel0};
                state_d = S_PAY;
            end
            S_PAY: begin
                payout    = pay_calc;
                win_amt_d = pay_calc[BAL_W-1:0];
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        coin_sum = (coin_1   ? AW'(1)   : '0) + (coin_10  ? AW'(10)  : '0) +
                   (coin_50  ? AW'(50)  : '0) + (coin_100 ? AW'(100) : '0);
        // Debit, coins and payout are folded into one update; saturate the total.
        sum       = AW'(balance_q) - debit + coin_sum + payout;
        balance_d = (sum > BAL_MAX) ? BAL_MAX[BAL_W-1:0] : sum[BAL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            reel_run_q     <= '0;
            bet_q          <= '0;
            digit_q        <= '0;
            balance_q      <= '0;
            win_amt_q      <= '0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            reel_run_q     <= reel_run_d;
            bet_q          <= bet_d;
            digit_q        <= digit_d;
            balance_q      <= balance_d;
            win_amt_q      <= win_amt_d;
            insufficient_q <= insufficient_d;
        end
    end

    assign reel_run     = reel_run_q;
    assign balance      = balance_q;
    assign win_amt      = win_amt_q;
    assign insufficient = insufficient_q;
    assign state        = state_q;
    assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl with SPIN_CYC=4, STAGGER=2.
// Spin accepted at edge N: SPIN at N+1, STOP at N+5, reels clear at N+5/7/9/11,
// EVAL at N+12, PAY at N+13, IDLE with the payout applied at N+14.
module tb_slot_game_ctrl;
    localparam int BAL_W = 27;
    localparam logic [BAL_W-1:0] MAXB = {BAL_W{1'b1}};
`ifdef SLOT_JACKPOT_EN
    localparam int JACK = 500;
`else
    localparam int JACK = 100;
`endif

    logic clk = 1'b0;
    logic rst, coin_1, coin_10, coin_50, coin_100, spin;
    logic [1:0] bet_sel;
    logic [3:0] reel0, reel1, reel2, reel3;
    logic [3:0] reel_run;
    logic [BAL_W-1:0] balance, win_amt;
    logic busy, insufficient;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    slot_game_ctrl #(.BAL_W(BAL_W), .SPIN_CYC(4), .STAGGER(2)) dut (
        .clk(clk), .rst(rst),
        .coin_1(coin_1), .coin_10(coin_10), .coin_50(coin_50), .coin_100(coin_100),
        .spin(spin), .bet_sel(bet_sel),
        .reel0(reel0), .reel1(reel1), .reel2(reel2), .reel3(reel3),
        .reel_run(reel_run), .balance(balance), .win_amt(win_amt),
        .busy(busy), .insufficient(insufficient), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic pulse_coin(input int which);
        coin_1   = (which == 1);
        coin_10  = (which == 10);
        coin_50  = (which == 50);
        coin_100 = (which == 100);
        step(1);
        {coin_1, coin_10, coin_50, coin_100} = 4'b0000;
    endtask

    task automatic set_reels(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        reel0 = a; reel1 = b; reel2 = c; reel3 = d;
    endtask

    task automatic do_spin(input logic [1:0] sel);
        spin    = 1'b1;
        bet_sel = sel;
        step(1);
        spin = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {coin_1, coin_10, coin_50, coin_100, spin} = 5'b0;
        bet_sel = 2'b00;
        set_reels(4'd0, 4'd0, 4'd0, 4'd0);
        step(2);
        chk("rst_balance", 64'(balance), 64'd0);
        chk("rst_win", 64'(win_amt), 64'd0);
        chk("rst_reel_run", 64'(reel_run), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_insuff", 64'(insufficient), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        rst = 1'b0;

        // Basic spin, no win, full stop sequence timing.
        pulse_coin(10);
        chk("coin10", 64'(balance), 64'd10);
        set_reels(4'd1, 4'd2, 4'd3, 4'd4);
        do_spin(2'b00);
        chk("s1_state_spin", 64'(state), 64'd1);
        chk("s1_run_f", 64'(reel_run), 64'hF);
        chk("s1_debit", 64'(balance), 64'd9);
        chk("s1_busy", 64'(busy), 64'd1);
        step(3);
        chk("s1_still_spin", 64'(state), 64'd1);
        chk("s1_run_f_last", 64'(reel_run), 64'hF);
        step(1);
        chk("s1_state_stop", 64'(state), 64'd2);
        chk("s1_run_e", 64'(reel_run), 64'hE);
        step(1);
        chk("s1_run_e_hold", 64'(reel_run), 64'hE);
        step(1);
        chk("s1_run_c", 64'(reel_run), 64'hC);
        step(2);
        chk("s1_run_8", 64'(reel_run), 64'h8);
        step(2);
        chk("s1_run_0", 64'(reel_run), 64'h0);
        chk("s1_stop_hold", 64'(state), 64'd2);
        step(1);
        chk("s1_eval", 64'(state), 64'd3);
        step(1);
        chk("s1_pay", 64'(state), 64'd4);
        step(1);
        chk("s1_idle", 64'(state), 64'd0);
        chk("s1_bal", 64'(balance), 64'd9);
        chk("s1_win", 64'(win_amt), 64'd0);

        // Rejected spin.
        do_reset();
        pulse_coin(1); pulse_coin(1); pulse_coin(1);
        chk("ins_bal_pre", 64'(balance), 64'd3);
        do_spin(2'b01);
        chk("ins_pulse", 64'(insufficient), 64'd1);
        chk("ins_state", 64'(state), 64'd0);
        chk("ins_bal", 64'(balance), 64'd3);
        step(1);
        chk("ins_pulse_end", 64'(insufficient), 64'd0);

        // Three of a kind, bet 10; bet_sel change after acceptance is ignored.
        do_reset();
        pulse_coin(100);
        set_reels(4'd5, 4'd5, 4'd5, 4'd2);
        do_spin(2'b10);
        bet_sel = 2'b11;
        chk("t3_debit", 64'(balance), 64'd90);
        step(13);
        chk("t3_state", 64'(state), 64'd0);
        chk("t3_bal", 64'(balance), 64'd190);
        chk("t3_win", 64'(win_amt), 64'd100);

        // Four of a kind, bet 10.
        do_reset();
        pulse_coin(100);
        set_reels(4'd5, 4'd5, 4'd5, 4'd5);
        do_spin(2'b10);
        chk("t4_debit", 64'(balance), 64'd90);
        step(13);
        chk("t4_bal", 64'(balance), 64'd1090);
        chk("t4_win", 64'(win_amt), 64'd1000);

        // Coins in the debit cycle, spin while busy, pair rule.
        do_reset();
        pulse_coin(10); pulse_coin(10);
        set_reels(4'd1, 4'd1, 4'd2, 4'd3);
        coin_50 = 1'b1; coin_100 = 1'b1;
        do_spin(2'b00);
        coin_50 = 1'b0; coin_100 = 1'b0;
        chk("mix_bal", 64'(balance), 64'd169);
        spin = 1'b1;
        step(1);
        spin = 1'b0;
        chk("busy_spin_state", 64'(state), 64'd1);
        chk("busy_spin_bal", 64'(balance), 64'd169);
        chk("busy_spin_insuff", 64'(insufficient), 64'd0);
        step(12);
        chk("pair_state", 64'(state), 64'd0);
        chk("pair_bal", 64'(balance), 64'd171);
        chk("pair_win", 64'(win_amt), 64'd2);

        // Saturation on payout.
        do_reset();
        force dut.balance_q = MAXB - 27'd9;
        #1;
        release dut.balance_q;
        set_reels(4'd3, 4'd3, 4'd3, 4'd3);
        do_spin(2'b00);
        chk("sat_debit", 64'(balance), 64'(MAXB - 27'd10));
        step(13);
        chk("sat_bal", 64'(balance), 64'(MAXB));
        chk("sat_win", 64'(win_amt), 64'd100);

        // Saturation on coin credit.
        do_reset();
        force dut.balance_q = MAXB - 27'd4;
        #1;
        release dut.balance_q;
        pulse_coin(100);
        chk("sat_coin", 64'(balance), 64'(MAXB));

        // Four 7s.
        do_reset();
        pulse_coin(10);
        set_reels(4'd7, 4'd7, 4'd7, 4'd7);
        do_spin(2'b00);
        step(13);
        chk("jack_win", 64'(win_amt), 64'(JACK));
        chk("jack_bal", 64'(balance), 64'(9 + JACK));

        // Reset in STOP.
        do_spin(2'b00);
        step(4);
        chk("rst_mid_in_stop", 64'(state), 64'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_bal", 64'(balance), 64'd0);
        chk("rst_mid_run", 64'(reel_run), 64'd0);
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
